// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage for the 8-bit mini CPU.
// Owns the 4-bit program counter, fetches instruction words over a req/ack
// handshake, buffers them in a small FIFO and hands them to decode over
// valid/ready. A redirect flushes everything and restarts at redirect_pc.
//
// Build option: define FETCH_PREFETCH_EN for a 2-entry prefetch queue that
// keeps fetching while decode stalls; without it a single-entry buffer is used
// and no request is issued while an instruction is held.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no memory request outstanding
// WAIT    | request outstanding, the returned word will be queued
// DISCARD | request outstanding, the returned word will be dropped
module instr_fetch #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  output logic [3:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_rdata,
  output logic [7:0] instr,
  output logic [3:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       redirect,
  input  logic [3:0] redirect_pc
);

`ifdef FETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [1:0] count, count_nx, cnt_pop;
  logic [3:0] fetch_pc, fetch_pc_nx;
  logic [3:0] addr_nx;
  logic [7:0] q_instr    [0:1];
  logic [3:0] q_pc       [0:1];
  logic [7:0] q_instr_nx [0:1];
  logic [3:0] q_pc_nx    [0:1];
  logic       pop, push;

  // Head of the queue is entry 0; outputs come straight from its flops.
  assign instr    = q_instr[0];
  assign instr_pc = q_pc[0];

  // Queue bookkeeping: pop first, then push behind whatever remains.
  always_comb begin
    pop        = instr_valid && instr_ready;
    // WAIT implies imem_req is high, so a stray ack in other states is ignored.
    push       = (state == WAIT) && imem_ack && !redirect;
    cnt_pop    = pop ? (count - 2'd1) : count;
    q_instr_nx = q_instr;
    q_pc_nx    = q_pc;
    if (pop) begin
      q_instr_nx[0] = q_instr[1];
      q_pc_nx[0]    = q_pc[1];
    end
    if (push) begin
      if (cnt_pop == 2'd0) begin
        q_instr_nx[0] = imem_rdata;
        q_pc_nx[0]    = imem_addr;
      end else begin
        q_instr_nx[1] = imem_rdata;
        q_pc_nx[1]    = imem_addr;
      end
    end
    // A redirect flushes after any same-cycle pop has been handed to decode.
    count_nx = redirect ? 2'd0 : (cnt_pop + {1'b0, push});
  end

  // Next-state, next fetch PC and next request address.
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    addr_nx     = imem_addr;
    case (state)
      IDLE: begin
        if (redirect) begin
          // New request goes out on the following edge.
          fetch_pc_nx = redirect_pc;
        end else if (cnt_pop < DEPTH) begin
          state_nx = WAIT;
          addr_nx  = fetch_pc;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          if (redirect) begin
            state_nx    = IDLE;
            fetch_pc_nx = redirect_pc;
          end else begin
            fetch_pc_nx = fetch_pc + 4'd1;
            if (count_nx < DEPTH) begin
              // Back-to-back request keeps imem_req high.
              addr_nx = fetch_pc + 4'd1;
            end else begin
              state_nx = IDLE;
            end
          end
        end else if (redirect) begin
          // imem_addr must stay stable until the stale response arrives.
          state_nx    = DISCARD;
          fetch_pc_nx = redirect_pc;
        end
      end
      DISCARD: begin
        if (redirect) begin
          fetch_pc_nx = redirect_pc;
        end
        if (imem_ack) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, queue and registered outputs; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= 2'd0;
      fetch_pc    <= RESET_PC;
      imem_addr   <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      q_instr[0]  <= 8'h00;
      q_instr[1]  <= 8'h00;
      q_pc[0]     <= 4'h0;
      q_pc[1]     <= 4'h0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      fetch_pc    <= fetch_pc_nx;
      imem_addr   <= addr_nx;
      imem_req    <= (state_nx != IDLE);
      instr_valid <= (count_nx != 2'd0);
      q_instr[0]  <= q_instr_nx[0];
      q_instr[1]  <= q_instr_nx[1];
      q_pc[0]     <= q_pc_nx[0];
      q_pc[1]     <= q_pc_nx[1];
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch, works with and without
// FETCH_PREFETCH_EN. Memory returns mem[a] = 8'h10 + a.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic [7:0] instr;
  logic [3:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       redirect = 1'b0;
  logic [3:0] redirect_pc = 4'h0;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model controls
  logic       mem_on = 1'b1;
  int         lat = 0;
  logic       man_ack = 1'b0;
  logic [7:0] man_rdata = 8'h00;

  instr_fetch #(.RESET_PC(4'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial forever #5 clk = ~clk;

  // Memory responder: updates ack/rdata mid-cycle; lat = extra wait cycles.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    imem_ack   = 1'b0;
    imem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_on) begin
        if (imem_req === 1'b1) begin
          if (wait_cnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = 8'h10 + {4'h0, imem_addr};
            wait_cnt   = 0;
          end else begin
            imem_ack = 1'b0;
            wait_cnt++;
          end
        end else begin
          imem_ack = 1'b0;
          wait_cnt = 0;
        end
      end else begin
        imem_ack   = man_ack;
        imem_rdata = man_rdata;
        wait_cnt   = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " imem_req"},    8'(imem_req),    8'h00);
    chk({tag, " imem_addr"},   8'(imem_addr),   8'h00);
    chk({tag, " instr"},       instr,           8'h00);
    chk({tag, " instr_pc"},    8'(instr_pc),    8'h00);
    chk({tag, " instr_valid"}, 8'(instr_valid), 8'h00);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

`ifndef FETCH_PREFETCH_EN
  // Single-entry buffer: a request is never outstanding while an entry is held.
  initial forever begin
    @(negedge clk);
    if (reset === 1'b0)
      chk("single_occupancy", 8'(instr_valid && imem_req), 8'h00);
  end
`endif

  typedef struct {
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_instr;
    logic [3:0] exp_pc;
    logic       exp_req;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [7:0] i,
                     input logic [3:0] p, input logic q);
    vec_t e;
    e.ready = r; e.exp_valid = v; e.exp_instr = i; e.exp_pc = p; e.exp_req = q;
    vecs.push_back(e);
  endtask

  initial begin
    logic [3:0] exp_pc;
    logic       exp_v;

    // Per-cycle vectors starting with the first cycle after reset release.
    // Decode stalls for the first 7 cycles, then accepts every cycle.
`ifdef FETCH_PREFETCH_EN
    add(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    add(1'b0, 1'b1, 8'h10, 4'h0, 1'b1);
    for (int k = 0; k < 5; k++) add(1'b0, 1'b1, 8'h10, 4'h0, 1'b0);
    add(1'b1, 1'b1, 8'h10, 4'h0, 1'b0);
    add(1'b1, 1'b1, 8'h11, 4'h1, 1'b1);
    add(1'b1, 1'b1, 8'h12, 4'h2, 1'b1);
`else
    add(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    for (int k = 0; k < 6; k++) add(1'b0, 1'b1, 8'h10, 4'h0, 1'b0);
    add(1'b1, 1'b1, 8'h10, 4'h0, 1'b0);
    add(1'b1, 1'b0, 8'h00, 4'h0, 1'b1);
    add(1'b1, 1'b1, 8'h11, 4'h1, 1'b0);
    add(1'b1, 1'b0, 8'h00, 4'h0, 1'b1);
    add(1'b1, 1'b1, 8'h12, 4'h2, 1'b0);
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;
    next_cycle();

    // Table-driven: stall, fill, release
    for (int i = 0; i < vecs.size(); i++) begin
      instr_ready = vecs[i].ready;
      chk($sformatf("vec%0d imem_req", i), 8'(imem_req), 8'(vecs[i].exp_req));
      chk($sformatf("vec%0d instr_valid", i), 8'(instr_valid), 8'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d instr", i), instr, vecs[i].exp_instr);
        chk($sformatf("vec%0d instr_pc", i), 8'(instr_pc), 8'(vecs[i].exp_pc));
      end
      next_cycle();
    end

    // Streaming through the PC wrap 4'hF -> 4'h0
    exp_pc = 4'h3;
`ifdef FETCH_PREFETCH_EN
    exp_v = 1'b1;
`else
    exp_v = 1'b0;
`endif
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("stream%0d instr_valid", c), 8'(instr_valid), 8'(exp_v));
`ifdef FETCH_PREFETCH_EN
      chk($sformatf("stream%0d imem_req", c), 8'(imem_req), 8'h01);
`endif
      if (exp_v) begin
        chk($sformatf("stream%0d instr_pc", c), 8'(instr_pc), 8'(exp_pc));
        chk($sformatf("stream%0d instr", c), instr, 8'h10 + {4'h0, exp_pc});
        exp_pc = exp_pc + 4'd1;
      end
`ifndef FETCH_PREFETCH_EN
      exp_v = ~exp_v;
`endif
      next_cycle();
    end

    // Redirect while WAIT with a slow memory: stale word is dropped
    reset = 1'b1;
    lat   = 2;
    next_cycle();
    next_cycle();
    chk_reset_vals("reset2");
    reset = 1'b0;
    next_cycle();
    chk("rd C1 imem_req", 8'(imem_req), 8'h01);
    chk("rd C1 imem_addr", 8'(imem_addr), 8'h00);
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 4'h9;
    next_cycle();
    redirect = 1'b0;
    chk("rd discard imem_req", 8'(imem_req), 8'h01);
    chk("rd discard imem_addr", 8'(imem_addr), 8'h00);
    chk("rd discard instr_valid", 8'(instr_valid), 8'h00);
    next_cycle();
    chk("rd drop imem_req", 8'(imem_req), 8'h00);
    chk("rd drop instr_valid", 8'(instr_valid), 8'h00);
    next_cycle();
    chk("rd new imem_req", 8'(imem_req), 8'h01);
    chk("rd new imem_addr", 8'(imem_addr), 8'h09);
    chk("rd new instr_valid", 8'(instr_valid), 8'h00);
    next_cycle();
    chk("rd wait1 instr_valid", 8'(instr_valid), 8'h00);
    next_cycle();
    chk("rd wait2 instr_valid", 8'(instr_valid), 8'h00);
    next_cycle();
    chk("rd first instr_valid", 8'(instr_valid), 8'h01);
    chk("rd first instr", instr, 8'h19);
    chk("rd first instr_pc", 8'(instr_pc), 8'h09);

    // Redirect coinciding with a pop (and, with prefetch, a same-cycle ack)
    lat         = 0;
    redirect    = 1'b1;
    redirect_pc = 4'h5;
    next_cycle();
    redirect = 1'b0;
    chk("rd2 flush instr_valid", 8'(instr_valid), 8'h00);
    chk("rd2 flush imem_req", 8'(imem_req), 8'h00);
    next_cycle();
    chk("rd2 req imem_req", 8'(imem_req), 8'h01);
    chk("rd2 req imem_addr", 8'(imem_addr), 8'h05);
    chk("rd2 req instr_valid", 8'(instr_valid), 8'h00);
    next_cycle();
    chk("rd2 first instr_valid", 8'(instr_valid), 8'h01);
    chk("rd2 first instr", instr, 8'h15);
    chk("rd2 first instr_pc", 8'(instr_pc), 8'h05);

    // Reset while a request is outstanding, late ack while imem_req=0
    mem_on  = 1'b0;
    man_ack = 1'b0;
    next_cycle();
    instr_ready = 1'b0;
    chk("rst pend imem_req", 8'(imem_req), 8'h01);
    chk("rst pend imem_addr", 8'(imem_addr), 8'h06);
    chk("rst pend instr_valid", 8'(instr_valid), 8'h00);
    reset = 1'b1;
    next_cycle();
    chk_reset_vals("rst mid");
    reset     = 1'b0;
    man_ack   = 1'b1;
    man_rdata = 8'hAA;
    next_cycle();
    man_ack = 1'b0;
    chk("rst new imem_req", 8'(imem_req), 8'h01);
    chk("rst new imem_addr", 8'(imem_addr), 8'h00);
    chk("rst late ack instr_valid", 8'(instr_valid), 8'h00);
    next_cycle();
    chk("rst hold instr_valid", 8'(instr_valid), 8'h00);
    chk("rst hold imem_addr", 8'(imem_addr), 8'h00);
    mem_on = 1'b1;
    next_cycle();
    chk("rst first instr_valid", 8'(instr_valid), 8'h01);
    chk("rst first instr", instr, 8'h10);
    chk("rst first instr_pc", 8'(instr_pc), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 8-bit mini CPU. It owns the 4-bit program counter and fetches 8-bit instruction words from instruction memory over a req/ack handshake. It buffers fetched words in a small prefetch queue and presents them to the decode/execute stage over a valid/ready handshake. It also accepts a PC redirect that flushes all in-flight and queued instructions.

## Interface
Parameters:
- RESET_PC, 4'h0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory. Held high with a stable imem_addr until imem_ack.
- imem_addr  out  4  fetch address.
- imem_ack  in  1  memory has returned imem_rdata this cycle. May be asserted in the same cycle imem_req is first seen. Ignored while imem_req=0.
- imem_rdata  in  8  instruction word. Valid only when imem_ack=1.
- instr  out  8  head-of-queue instruction to decode.
- instr_pc  out  4  address instr was fetched from.
- instr_valid  out  1  instr/instr_pc are valid.
- instr_ready  in  1  decode accepts instr this cycle.
- redirect  in  1  one-cycle pulse: discard all fetched and pending instructions and resume at redirect_pc.
- redirect_pc  in  4  new fetch address. Sampled only when redirect=1.

## Operation
- Queue depth DEPTH is 2 with FETCH_PREFETCH_EN defined, 1 without it. Entries are {instr, pc}, FIFO order.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response will be kept.
  - DISCARD: request outstanding, response will be dropped.
- IDLE -> WAIT when count < DEPTH; imem_addr = fetch_pc.
- WAIT + ack: push {imem_rdata, imem_addr}; fetch_pc increments. Stay in WAIT if post-edge count < DEPTH, else go to IDLE.
- Occupancy invariant: count + (outstanding ? 1 : 0) <= DEPTH at all times.
- PC arithmetic is 4-bit modulo: 4'hF + 1 = 4'h0; wrap-around is silent.
- Pop occurs when instr_valid && instr_ready. Push and pop in the same cycle is allowed; count stays unchanged.
- Redirect:
  - Queue is flushed (count = 0) and fetch_pc = redirect_pc.
  - From IDLE: go to IDLE, with the new request issued on the following edge.
  - From WAIT without ack: go to DISCARD.
  - From WAIT with ack in the same cycle: data is dropped and the FSM goes to IDLE.
- DISCARD + ack: data dropped, FSM goes to IDLE. A redirect in DISCARD only updates fetch_pc.
- Redirect and a pop in the same cycle: the pop completes (decode owns that instruction), then the flush applies.
- Reset has priority over all other inputs, including redirect and ack.

## Timing
- All outputs are registered.
- Reset values:
  - imem_req = 0, imem_addr = RESET_PC
  - instr = 8'h00, instr_pc = 4'h0, instr_valid = 0
  - FSM = IDLE, count = 0, fetch_pc = RESET_PC
- First request: imem_req rises after the first edge with reset=0.
- Latency: ack at edge N gives instr_valid=1 after edge N (available from cycle N+1).
- Zero-wait memory with instr_ready held at 1:
  - With FETCH_PREFETCH_EN: one instruction per cycle, and imem_req stays high continuously.
  - Without it: one instruction every 2 cycles.
- instr and instr_pc hold stable while instr_valid=1 and instr_ready=0.
- After a redirect edge, instr_valid=0 until the first post-redirect ack is pushed.
- Reset asserted mid-transaction: all outputs take their reset values at that edge. A late ack arriving while imem_req=0 is ignored.

## Configuration
- FETCH_PREFETCH_EN defined: 2-entry queue. Requests continue while the head instruction is stalled, hiding one cycle of memory latency.
- Not defined: 1-entry buffer. No request is issued while an instruction is held. The interface and all other behaviour are identical.

## Test plan
- Reset release, zero-wait memory returning mem[a] = 8'h10 + a, instr_ready=1, macro on -> instr 8'h10, 8'h11, 8'h12 on consecutive cycles with instr_pc 0, 1, 2.
- Hold instr_ready=0 for 6 cycles after the first instr_valid -> queue fills to 2 and imem_req drops. instr stays 8'h10 and instr_pc stays 0. After release, 8'h11 follows on the next cycle.
- Run to PC 4'hF -> instr_pc 4'hF is followed by instr_pc 4'h0 with instr 8'h10; no X and no stall.
- 3-cycle memory latency, redirect_pc = 4'h9 pulsed while in WAIT -> the stale response is dropped and the next instr_valid carries instr_pc 4'h9, instr 8'h19.
- Reset asserted during WAIT, with ack arriving in the cycle after reset -> all outputs at reset values, ack ignored, the first new request to RESET_PC.
- Macro off, zero-wait memory, instr_ready=1 -> instr_valid toggles 1, 0, 1, 0 with instr_pc 0, 1, 2; count never exceeds 1.
